tage_hist_sequencer: RTL

//  Sequences the commit of resolved branches into the TAGE global/path history register block.

---
 rtl/tage_hist_sequencer_pkg.sv | 20 ++
 rtl/tage_hist_sequencer_fifo.sv | 47 ++++
 rtl/tage_hist_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tage_hist_sequencer_pkg.sv
// Shared definitions for the TAGE history commit sequencer: FSM state encoding
// and watchdog timer sizing.
package tage_hist_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } seq_state_e;

    // Wide enough for any watchdog limit up to 255 cycles.
    localparam int TIMER_W = 8;

    // Timer value on the last WAIT cycle before the watchdog forces the shift.
    function automatic logic [TIMER_W-1:0] timer_last(input int timeout);
        return TIMER_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/tage_hist_sequencer_fifo.sv
// In-order resolution queue: DEPTH x W circular buffer with push, pop, flush
// and occupancy count. Storage is not reset; only pointers and count are.
module hist_req_fifo
    import tage_hist_sequencer_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tage_hist_sequencer.sv
// Commits resolved branches to the TAGE history in order: table update first,
// then one history shift, with a watchdog that forces the shift on a lost done.
module tage_hist_sequencer
    import tage_hist_sequencer_pkg::*;
#(
    parameter int PC_LEN  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_LEN-1:0]      in_pc,
    input  logic                   in_taken,
    input  logic                   flush,
    output logic                   upd_req,
    output logic [PC_LEN-1:0]      upd_pc,
    output logic                   upd_taken,
    input  logic                   upd_done,
    output logic                   hist_en,
    output logic [PC_LEN-1:0]      hist_pc,
    output logic                   hist_taken,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int                 CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = timer_last(TIMEOUT);

    seq_state_e         state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               timed_out, timed_out_nxt;
    logic [PC_LEN-1:0]  work_pc;
    logic               work_taken;

    logic               active;
    logic               push;
    logic               pop;
    logic [PC_LEN:0]    pop_data;

    // Reset low or flush suppresses every strobe and queue movement this cycle.
    assign active   = reset && !flush;
    assign in_ready = (count < CNT_W'(DEPTH)) && active;
    assign push     = in_valid && in_ready;

    hist_req_fifo #(
        .W     (PC_LEN + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({in_taken, in_pc}),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (count)
    );

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        timed_out_nxt = timed_out;
        pop           = 1'b0;
        upd_req       = 1'b0;
        hist_en       = 1'b0;
        timeout_err   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                upd_req       = 1'b1;
                timer_nxt     = '0;
                timed_out_nxt = 1'b0;
                state_nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                if (upd_done) begin
                    state_nxt = ST_SHIFT;
                end else if (timer == TIMER_LAST) begin
                    state_nxt     = ST_SHIFT;
                    timed_out_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_SHIFT: begin
                hist_en     = 1'b1;
                timeout_err = timed_out;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The in-flight entry is dropped without a shift; a late done lands in IDLE.
        if (!active) begin
            pop           = 1'b0;
            upd_req       = 1'b0;
            hist_en       = 1'b0;
            timeout_err   = 1'b0;
            state_nxt     = ST_IDLE;
            timer_nxt     = '0;
            timed_out_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            timed_out  <= 1'b0;
            work_pc    <= '0;
            work_taken <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            timed_out <= timed_out_nxt;
            if (pop) begin
                work_pc    <= pop_data[PC_LEN-1:0];
                work_taken <= pop_data[PC_LEN];
            end
        end
    end

    assign upd_pc     = work_pc;
    assign upd_taken  = work_taken;
    assign hist_pc    = work_pc;
    assign hist_taken = work_taken;
    assign busy       = (state != ST_IDLE) || (count != '0);

endmodule
